// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared state encoding and widths for the ALU load controller
package alu_ctrl_pkg;

    localparam int STATE_W    = 2;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [STATE_W-1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RES = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchroniser followed by a rising-edge one-cycle pulse
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    // One pulse per rising edge of the synchronised level, however long it is held.
    assign pulse = chain[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/alu_load_ctrl.sv
// rtl/alu_load_ctrl.sv - sequences A/B/opcode loads from one switch bus and one button
module alu_load_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              clr,
    input  logic [DATA_W-1:0] sw,
    output logic [DATA_W-1:0] d_out,
    output logic              en_a,
    output logic              en_b,
    output logic              en_op,
    output logic              regs_rst,
    output logic              result_valid,
    output logic [1:0]        state_o
);

    logic btn_ev;
    logic clr_ev;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (btn),
        .pulse (btn_ev)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (clr),
        .pulse (clr_ev)
    );

    state_t            state_q;
    state_t            state_n;
    logic [DATA_W-1:0] d_n;
    logic              en_a_n;
    logic              en_b_n;
    logic              en_op_n;
    logic              regs_rst_n;
    logic              result_valid_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_A;
            d_out        <= '0;
            en_a         <= 1'b0;
            en_b         <= 1'b0;
            en_op        <= 1'b0;
            regs_rst     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state_q      <= state_n;
            d_out        <= d_n;
            en_a         <= en_a_n;
            en_b         <= en_b_n;
            en_op        <= en_op_n;
            regs_rst     <= regs_rst_n;
            result_valid <= result_valid_n;
        end
    end

    always_comb begin
        state_n    = state_q;
        d_n        = d_out;
        en_a_n     = 1'b0;
        en_b_n     = 1'b0;
        en_op_n    = 1'b0;
        regs_rst_n = 1'b0;
        // Clear outranks a coincident press; the press is dropped.
        if (clr_ev) begin
            state_n    = S_A;
            d_n        = '0;
            regs_rst_n = 1'b1;
        end else if (btn_ev) begin
            case (state_q)
                S_A: begin
                    d_n     = sw;
                    en_a_n  = 1'b1;
                    state_n = S_B;
                end
                S_B: begin
                    d_n     = sw;
                    en_b_n  = 1'b1;
                    state_n = S_OP;
                end
                S_OP: begin
                    d_n     = sw;
                    en_op_n = 1'b1;
                    state_n = S_RES;
                end
                S_RES:   state_n = S_A;
                default: state_n = S_A;
            endcase
        end
        result_valid_n = (state_n == S_RES);
    end

    assign state_o = state_q;

endmodule
